// File: rtl/daq_wb_master.sv
// Wishbone B3 classic single-transfer master fed by the DAQ file state machine.
// Optional macro DAQ_WB_TIMEOUT_EN adds a termination timeout and the bus_timeout flag.
module daq_wb_master #(
    parameter int dw             = 32,
    parameter int aw             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          start,
    input  logic [aw-1:0] address,
    input  logic [3:0]    selection,
    input  logic          write,
    input  logic [dw-1:0] data_wr,
    output logic [dw-1:0] data_rd,
    output logic          active,
    output logic          bus_error,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    output logic          bus_timeout
);

    typedef enum logic {IDLE, BUS} state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    state_t        state_q, state_d;
    logic          armed_q, armed_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic          berr_q, berr_d;
    logic [aw-1:0] adr_q, adr_d;
    logic [dw-1:0] dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic [dw-1:0] rd_q, rd_d;

`ifdef DAQ_WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
`endif

    always_comb begin
        state_d = state_q;
        // Re-arms on any low sample of start; the stale level of the last request stays inert.
        armed_d = armed_q | ~start;
        cyc_d   = cyc_q;
        we_d    = we_q;
        berr_d  = berr_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
`ifdef DAQ_WB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && armed_q) begin
                    adr_d   = address;
                    sel_d   = selection;
                    we_d    = write;
                    dat_d   = write ? data_wr : '0;
                    cyc_d   = 1'b1;
                    armed_d = 1'b0;
                    state_d = BUS;
`ifdef DAQ_WB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUS: begin
                // err outranks ack when both arrive together.
                if (wb_err_i) begin
                    berr_d  = 1'b1;
                    if (!we_q) rd_d = '0;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else if (wb_ack_i) begin
                    if (!we_q) rd_d = wb_dat_i;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
`ifdef DAQ_WB_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    berr_d  = 1'b1;
                    tmo_d   = 1'b1;
                    if (!we_q) rd_d = '0;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            berr_q  <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rd_q    <= '0;
`ifdef DAQ_WB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            berr_q  <= berr_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
`ifdef DAQ_WB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign active    = cyc_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign data_rd   = rd_q;
    assign bus_error = berr_q;
`ifdef DAQ_WB_TIMEOUT_EN
    assign bus_timeout = tmo_q;
`else
    assign bus_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_daq_wb_master.sv
// Scoreboard bench for daq_wb_master: stimulus pushes expected transfers, a monitor checks each completion.
module tb_daq_wb_master;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic        start;
    logic [31:0] address;
    logic [3:0]  selection;
    logic        write;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        active;
    logic        bus_error;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        bus_timeout;

    daq_wb_master #(.dw(32), .aw(32), .TIMEOUT_CYCLES(16)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .address(address),
        .selection(selection), .write(write), .data_wr(data_wr), .data_rd(data_rd),
        .active(active), .bus_error(bus_error), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .bus_timeout(bus_timeout)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          width;
        logic [31:0] rd;
        logic        berr;
        logic        btmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_exp  = 0;
    int   n_cyc  = 0;
    logic tmo_exp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    // lat>0: respond on the lat-th edge after accept; lat=0: never respond.
    task automatic xfer(input logic [31:0] adr, input logic [3:0] sel, input logic we,
                        input logic [31:0] wdat, input logic [31:0] rdat, input int lat,
                        input logic ack, input logic err, input int hold,
                        input logic [31:0] e_dat, input logic [31:0] e_rd,
                        input logic e_berr, input logic e_btmo, input int e_w);
        exp_t e;
        int   n;
        e = '{adr, e_dat, sel, we, e_w, e_rd, e_berr, e_btmo};
        exp_q.push_back(e);
        n_exp++;
        address = adr; selection = sel; write = we; data_wr = wdat; start = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!active && n < 10);
        if (!active) begin
            chk("accept_timeout", 32'(active), 32'd1);
            start = 1'b0;
            tick();
            return;
        end
        if (lat > 0) begin
            repeat (lat - 1) tick();
            wb_ack_i = ack; wb_err_i = err; wb_dat_i = rdat;
            tick();
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
        end else begin
            n = 0;
            while (active && n < 40) begin tick(); n++; end
            if (active) chk("no_abort", 32'(active), 32'd0);
        end
        repeat (hold) tick();
        start = 1'b0;
        tick();
    endtask

    // Monitor: snapshots a transfer while active, compares on the falling edge of active.
    initial begin : monitor
        logic        in_xfer, unstable, rst_seen;
        logic [31:0] s_adr, s_dat;
        logic [3:0]  s_sel;
        logic        s_we;
        int          w;
        exp_t        e;
        in_xfer = 0; unstable = 0; rst_seen = 0; w = 0;
        s_adr = 0; s_dat = 0; s_sel = 0; s_we = 0;
        forever begin
            @(negedge wb_clk);
            if (wb_rst) rst_seen = 1;
            if (active) begin
                if (!in_xfer) begin
                    in_xfer = 1; w = 0; unstable = 0; n_cyc++;
                    s_adr = wb_adr_o; s_dat = wb_dat_o; s_sel = wb_sel_o; s_we = wb_we_o;
                end else if (wb_adr_o !== s_adr || wb_dat_o !== s_dat ||
                             wb_sel_o !== s_sel || wb_we_o !== s_we) begin
                    unstable = 1;
                end
                if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) unstable = 1;
                w++;
            end else begin
                if (in_xfer) begin
                    in_xfer = 0;
                    if (!rst_seen) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_cycle", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("adr",       s_adr,          e.adr);
                            chk("dat_o",     s_dat,          e.dat);
                            chk("sel",       32'(s_sel),     32'(e.sel));
                            chk("we",        32'(s_we),      32'(e.we));
                            chk("width",     32'(w),         32'(e.width));
                            chk("stable",    32'(unstable),  32'd0);
                            chk("data_rd",   data_rd,        e.rd);
                            chk("bus_error", 32'(bus_error), 32'(e.berr));
                            chk("timeout",   32'(bus_timeout), 32'(e.btmo));
                            chk("idle_bus",  {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
                        end
                    end
                end
                if (!wb_rst) rst_seen = 0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        wb_rst = 1; start = 0; address = 0; selection = 0; write = 0; data_wr = 0;
        wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0;
        repeat (3) tick();
        chk("rst_active",  32'(active),  32'd0);
        chk("rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("rst_we",      32'(wb_we_o), 32'd0);
        chk("rst_berr",    32'(bus_error), 32'd0);
        chk("rst_tmo",     32'(bus_timeout), 32'd0);
        chk("rst_data_rd", data_rd,  32'd0);
        chk("rst_adr",     wb_adr_o, 32'd0);
        chk("rst_dat_o",   wb_dat_o, 32'd0);
        chk("rst_sel",     32'(wb_sel_o), 32'd0);
        wb_rst = 0;
        tick();

        // adr sel we wdat rdat lat ack err hold | e_dat e_rd e_berr e_btmo e_w
        xfer(32'h100, 4'hF, 0, 32'hAAAA5555, 32'hDEADBEEF, 3, 1, 0, 0,
             32'h0, 32'hDEADBEEF, 0, 0, 3);
        // Write held high 2 cycles past completion, then low 1 cycle, then a read.
        xfer(32'h204, 4'hF, 1, 32'h12345678, 32'hFFFFFFFF, 1, 1, 0, 2,
             32'h12345678, 32'hDEADBEEF, 0, 0, 1);
        xfer(32'h208, 4'h3, 0, 32'hAAAA5555, 32'h0000CAFE, 2, 1, 0, 0,
             32'h0, 32'h0000CAFE, 0, 0, 2);
        xfer(32'h300, 4'hF, 0, 32'h0, 32'h55AA55AA, 16, 1, 0, 0,
             32'h0, 32'h55AA55AA, 0, 0, 16);
`ifdef DAQ_WB_TIMEOUT_EN
        xfer(32'h400, 4'hF, 0, 32'h0, 32'h13579BDF, 0, 0, 0, 0,
             32'h0, 32'h0, 1, 1, 16);
        tmo_exp = 1'b1;
`else
        xfer(32'h400, 4'hF, 0, 32'h0, 32'h13579BDF, 20, 1, 0, 0,
             32'h0, 32'h13579BDF, 0, 0, 20);
`endif
        xfer(32'h500, 4'hF, 0, 32'h0, 32'hFFFFFFFF, 2, 1, 1, 0,
             32'h0, 32'h0, 1, tmo_exp, 2);
        xfer(32'h600, 4'hC, 1, 32'hA5A5A5A5, 32'h11111111, 1, 1, 0, 0,
             32'hA5A5A5A5, 32'h0, 1, tmo_exp, 1);
        xfer(32'h604, 4'h1, 0, 32'h0, 32'h0BADF00D, 1, 1, 0, 0,
             32'h0, 32'h0BADF00D, 1, tmo_exp, 1);

        // Reset in the middle of a read: no completion, stale start ignored afterwards.
        n_exp++;
        address = 32'h700; selection = 4'hF; write = 0; data_wr = 0; start = 1;
        tick();
        chk("pre_rst_active", 32'(active), 32'd1);
        tick();
        wb_rst = 1;
        tick();
        wb_rst = 0;
        chk("mid_rst_active",  32'(active), 32'd0);
        chk("mid_rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("mid_rst_berr",    32'(bus_error), 32'd0);
        chk("mid_rst_tmo",     32'(bus_timeout), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stale_start", 32'(active), 32'd0);
        end
        start = 0;
        tick();
        xfer(32'h800, 4'hF, 0, 32'h0, 32'h600DF00D, 2, 1, 0, 0,
             32'h0, 32'h600DF00D, 0, 0, 2);

        repeat (3) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("cycle_count", 32'(n_cyc), 32'(n_exp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
